// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM encoding and operand-sign helpers for the
// iterative integer ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ITER  = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

    // Operand A is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == M_MULH) || (f3 == M_MULHSU) || (f3 == M_DIV) || (f3 == M_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == M_MULH) || (f3 == M_DIV) || (f3 == M_REM);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv_core.sv
// One-bit-per-cycle shift-add multiplier / restoring divider working on operand
// magnitudes, with the sign fix-up applied combinationally on the final state.
module muldiv_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CW   = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            last_o,
    output logic [XLEN-1:0] res_o
);

    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      fn_q, fn_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic            bzero_q, bzero_d;

    logic            sa, sb;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix;

    assign sa    = a_is_signed(funct3_i) & a_i[XLEN-1];
    assign sb    = b_is_signed(funct3_i) & b_i[XLEN-1];
    assign abs_a = sa ? -a_i : a_i;
    assign abs_b = sb ? -b_i : b_i;

    // Multiply: acc holds the running upper half, lo shifts the multiplier out.
    assign mul_sum   = {1'b0, acc_q} + {1'b0, {XLEN{lo_q[0]}} & mcand_q};
    // Divide: acc is the partial remainder, lo shifts dividend out / quotient in.
    assign div_shift = {acc_q, lo_q[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, mcand_q};
    assign div_diff  = div_shift[XLEN-1:0] - mcand_q;

    always_comb begin
        acc_d   = acc_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        fn_d    = fn_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        bzero_d = bzero_q;
        if (load_i) begin
            fn_d    = funct3_i;
            neg_a_d = sa;
            neg_b_d = sb;
            bzero_d = (b_i == '0);
            cnt_d   = CW'(XLEN);
            acc_d   = '0;
            if (is_div_op(funct3_i)) begin
                lo_d    = abs_a;
                mcand_d = abs_b;
            end else begin
                lo_d    = abs_b;
                mcand_d = abs_a;
            end
        end else if (step_i) begin
            cnt_d = cnt_q - CW'(1);
            if (is_div_op(fn_q)) begin
                acc_d = div_ge ? div_diff : div_shift[XLEN-1:0];
                lo_d  = {lo_q[XLEN-2:0], div_ge};
            end else begin
                acc_d = mul_sum[XLEN:1];
                lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            fn_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            bzero_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            fn_q    <= fn_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            bzero_q <= bzero_d;
        end
    end

    assign last_o = (cnt_q == CW'(1));

    // A zero divisor yields an all-ones magnitude quotient that must stay unnegated.
    assign prod     = {acc_q, lo_q};
    assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
    assign quo_fix  = ((neg_a_q ^ neg_b_q) && !bzero_q) ? -lo_q : lo_q;
    assign rem_fix  = neg_a_q ? -acc_q : acc_q;

    always_comb begin
        res_o = '0;
        case (fn_q)
            M_MUL:                     res_o = prod_fix[XLEN-1:0];
            M_MULH, M_MULHSU, M_MULHU: res_o = prod_fix[2*XLEN-1:XLEN];
            M_DIV, M_DIVU:             res_o = quo_fix;
            default:                   res_o = rem_fix;
        endcase
    end

endmodule

// File: rtl/alu_iter.sv
// Handshaked EXECUTE-stage ALU: single-cycle RV32I base ops inline, RV32M ops
// on the iterative muldiv_core, sequenced by a four-state FSM.
module alu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN),
    parameter int CW   = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] base_res;
    logic            md_load, md_step, md_last;
    logic [XLEN-1:0] md_res;
    logic [SHW-1:0]  shamt;

    assign shamt = b[SHW-1:0];

    always_comb begin
        base_res = '0;
        case (op[3:0])
            ALU_ADD:  base_res = a + b;
            ALU_SUB:  base_res = a - b;
            ALU_AND:  base_res = a & b;
            ALU_OR:   base_res = a | b;
            ALU_XOR:  base_res = a ^ b;
            ALU_SLL:  base_res = a << shamt;
            ALU_SRL:  base_res = a >> shamt;
            ALU_SRA:  base_res = $signed(a) >>> shamt;
            ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, a < b};
            default:  base_res = '0;
        endcase
    end

    // flush wins over everything, including a start in the same cycle.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        md_load  = 1'b0;
        md_step  = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (op[4]) begin
                            md_load = 1'b1;
                            state_d = ST_ITER;
                        end else begin
                            result_d = base_res;
                            state_d  = ST_DONE;
                        end
                    end
                end
                ST_ITER: begin
                    md_step = 1'b1;
                    if (md_last) state_d = ST_FINAL;
                end
                ST_FINAL: begin
                    result_d = md_res;
                    state_d  = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    muldiv_core #(
        .XLEN(XLEN),
        .CW  (CW)
    ) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (md_load),
        .step_i  (md_step),
        .funct3_i(op[2:0]),
        .a_i     (a),
        .b_i     (b),
        .last_o  (md_last),
        .res_o   (md_res)
    );

    assign busy   = (state_q == ST_ITER) || (state_q == ST_FINAL);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised, handshaked successor to the single-cycle integer ALU.
- Executes the base RV32I ALU operations plus the full RV32M multiply/divide set.
- M-extension operations run on an iterative one-bit-per-cycle shift-add / restoring-divide datapath.
- Sits in the EXECUTE stage of the multicycle core; the control FSM stalls on busy and advances on done.

Parameters:
- XLEN, 32, operand/result width; power of two, >=8.
- SHW, $clog2(XLEN), shift-amount width taken from b[SHW-1:0].
- CW, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  input  1  core clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only when busy=0.
- op  input  5  op[4]=0: base op, op[3:0] = base ALU code; op[4]=1: M op, op[2:0] = RV32M funct3, op[3] ignored.
- a  input  XLEN  operand A (rs1), sampled on accept.
- b  input  XLEN  operand B (rs2/imm), sampled on accept.
- flush  input  1  abandons any in-flight operation.
- busy  output  1  high from the accept edge until done, or until flush.
- done  output  1  one-cycle pulse; result valid in that cycle.
- result  output  XLEN  registered; holds its value until the next done.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, counter=0, internal accumulators=0.
- Base ALU codes:
  - 0000 add, 1000 sub, 0111 and, 0110 or, 0100 xor.
  - 0001 sll, 0101 srl, 1101 sra.
  - 0010 slt (signed), 0011 sltu.
  - Any other code gives result=0.
  - Shifts use b[SHW-1:0]. Add/sub wrap modulo 2^XLEN.
- M funct3:
  - 000 MUL = low XLEN bits of the product.
  - 001 MULH = high half, signed x signed.
  - 010 MULHSU = high half, signed a x unsigned b.
  - 011 MULHU = high half, unsigned x unsigned.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states IDLE, ITER, FINAL, DONE.
  - IDLE: on start, latch a, b, op and assert busy.
    - Base op: result computed and registered, go to DONE (done high the cycle after the accept edge, latency 1).
    - M op: record operand signs, convert operands to magnitudes, counter=XLEN, go to ITER.
  - ITER: one partial-product add or one restoring-subtract step per cycle; counter decrements; at counter==1 go to FINAL. XLEN cycles in ITER.
  - FINAL: apply sign correction (two's-complement negate of the 2*XLEN product, or of quotient/remainder), select the half, register result, go to DONE.
  - DONE: done=1, busy=0 this cycle, return to IDLE.
  - M-op latency: done asserted XLEN+2 edges after the accept edge (34 for XLEN=32), fixed for all operand values.
- Divide by zero:
  - DIV/DIVU quotient = all ones.
  - REM/REMU remainder = a.
  - Full latency still applies.
- Signed overflow (a = most-negative, b = -1):
  - DIV = most-negative.
  - REM = 0.
- Remainder sign follows the dividend; quotient truncates toward zero.
- start while busy=1 is ignored; operands are not re-sampled.
- start in the DONE cycle is ignored; the earliest re-accept is the following IDLE cycle.
- flush=1, any state: next edge goes to IDLE, busy=0, no done pulse, result unchanged.
  - flush has priority over start in the same cycle (the start is dropped).
- rst_n deasserting mid-operation: block resumes in IDLE, no spurious done.
- busy and done are never high in the same cycle. done is never high two consecutive cycles.

Decomposition:
- Shared package alu_pkg holds:
  - localparams for the base ALU codes (ALU_ADD=4'b0000 … ALU_SLTU=4'b0011);
  - M funct3 codes (M_MUL … M_REMU);
  - the FSM state encoding.
- One sub-module: muldiv_core (ITER/FINAL datapath: accumulator, shift register, counter, sign fix). Base ops stay inline in alu_iter.

Test Plan:
- Base op: op=0_1000, a=5, b=7 -> done 1 cycle after accept, result=32'hFFFFFFFE; op=0_1101, a=32'h80000000, b=4 -> 32'hF8000000.
- MUL/MULH: a=-3, b=7, MULH -> 32'hFFFFFFFF, MUL -> 32'hFFFFFFEB; MULHU a=b=32'hFFFFFFFF -> 32'hFFFFFFFE; done exactly 34 edges after accept.
- Division edges: DIV -7/2 -> quotient 32'hFFFFFFFD, REM -> 32'hFFFFFFFF; DIVU x/0 -> 32'hFFFFFFFF; REM 9/0 -> 9; DIV 32'h80000000 / -1 -> 32'h80000000, REM -> 0.
- Handshake: start pulsed during ITER with different operands -> ignored, original result delivered; back-to-back starts on consecutive idle cycles each produce exactly one done.
- Flush: flush asserted at cycle 10 of a DIV -> busy drops next edge, no done, result retains the previous value; start+flush in the same cycle -> no accept.
- Reset: rst_n pulled low mid-MUL asynchronously -> busy=0, done=0, result=0 immediately; new op after release completes normally.
